// File: rtl/ca_gen_scheduler_if.sv
// Engine handshake bundle between the generation scheduler and the update engine.
interface ca_gen_scheduler_if;
  logic eng_start;
  logic eng_hold;
  logic mem_grant_eng;
  logic eng_done;

  modport master (
    output eng_start,
    output eng_hold,
    output mem_grant_eng,
    input  eng_done
  );

  modport slave (
    input  eng_start,
    input  eng_hold,
    input  mem_grant_eng,
    output eng_done
  );
endinterface

// File: rtl/ca_gen_scheduler.sv
// ca_gen_scheduler: paces cellular-automaton generations against VGA frames.
// The engine only touches cell memory during vertical blanking, and the
// displayed buffer flips only in blanking so the picture never tears.
module ca_gen_scheduler #(
  parameter int GEN_DIV = 4,
  parameter int FDIV_W  = 3,
  parameter int GEN_W   = 16
) (
  input  logic               vga_clk,
  input  logic               clrn,
  input  logic               vblank,
  input  logic               frame_tick,
  input  logic               run_en,
  input  logic               step_req,
  ca_gen_scheduler_if.master eng,
  output logic               disp_buf,
  output logic [GEN_W-1:0]   gen_count,
  output logic               busy,
  output logic               late
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_SWAP = 2'd3;

  localparam logic [FDIV_W-1:0] FDIV_LAST = FDIV_W'(GEN_DIV - 1);

  logic [1:0]        state_q, state_d;
  logic [FDIV_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              step_pend_q, step_pend_d;
  logic              eng_start_q, eng_start_d;
  logic              eng_hold_q, eng_hold_d;
  logic              grant_q, grant_d;
  logic              disp_buf_q, disp_buf_d;
  logic [GEN_W-1:0]  gen_count_q, gen_count_d;
  logic              busy_q, busy_d;
  logic              late_q, late_d;
  logic              launch;

  // Next-state logic: frame dividing, launch decision, blanking-window tracking and swap.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    disp_buf_d  = disp_buf_q;
    gen_count_d = gen_count_q;
    late_d      = late_q;
    launch      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          if (step_pend_q || (run_en && (frame_cnt_q == FDIV_LAST))) begin
            launch = 1'b1;
          end else if (run_en) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
          if (launch) begin
            frame_cnt_d = '0;
            state_d     = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (eng.eng_done) begin
          state_d = ST_SWAP;
        end else if (!vblank) begin
          state_d = ST_HOLD;
          late_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (eng.eng_done) begin
          state_d = ST_SWAP;
        end else if (frame_tick) begin
          state_d = ST_RUN;
        end
      end
      ST_SWAP: begin
        if (vblank) begin
          disp_buf_d  = ~disp_buf_q;
          gen_count_d = gen_count_q + 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    step_pend_d = step_req | (step_pend_q & ~launch);
    eng_start_d = launch;
    grant_d     = (state_d == ST_RUN);
    eng_hold_d  = (state_d == ST_HOLD);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered outputs, cleared asynchronously by clrn.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      step_pend_q <= 1'b0;
      eng_start_q <= 1'b0;
      eng_hold_q  <= 1'b0;
      grant_q     <= 1'b0;
      disp_buf_q  <= 1'b0;
      gen_count_q <= '0;
      busy_q      <= 1'b0;
      late_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      step_pend_q <= step_pend_d;
      eng_start_q <= eng_start_d;
      eng_hold_q  <= eng_hold_d;
      grant_q     <= grant_d;
      disp_buf_q  <= disp_buf_d;
      gen_count_q <= gen_count_d;
      busy_q      <= busy_d;
      late_q      <= late_d;
    end
  end

  assign eng.eng_start     = eng_start_q;
  assign eng.eng_hold      = eng_hold_q;
  assign eng.mem_grant_eng = grant_q;
  assign disp_buf          = disp_buf_q;
  assign gen_count         = gen_count_q;
  assign busy              = busy_q;
  assign late              = late_q;

endmodule
